// File: rtl/grf_param.sv
// grf_param: parameterised register file with two combinational read ports,
// one write port, a committed-write counter and a comparator between the
// two read ports.
//
// Optional feature macro: GRF_BYPASS_EN
//   When defined, a committed write is forwarded to any read port addressing
//   the same location in the same cycle. When undefined, reads return the
//   pre-edge contents and there is no forwarding logic at all.
//
// Ports:
//   clk       in   system clock, all state updates on the rising edge
//   reset     in   synchronous active-high reset (clears array and counter)
//   we        in   write enable
//   waddr     in   write address [ADDR_W]
//   wdata     in   write data [DATA_W]
//   raddr1/2  in   read addresses [ADDR_W]
//   rdata1/2  out  combinational read data [DATA_W]
//   eq        out  rdata1 == rdata2
//   lt_s      out  rdata1 < rdata2, two's complement
//   lt_u      out  rdata1 < rdata2, unsigned
//   wr_count  out  number of committed writes, wraps at 16 bits
module grf_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              eq,
  output logic              lt_s,
  output logic              lt_u,
  output logic [15:0]       wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              commit;

  // Writes to a hard-wired zero register are dropped and not counted.
  assign commit = we && !(ZERO_EN && (waddr == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_count <= '0;
    end else if (commit) begin
      mem[waddr] <= wdata;
      wr_count   <= wr_count + 16'd1;
    end
  end

  always_comb begin
    rdata1 = mem[raddr1];
`ifdef GRF_BYPASS_EN
    if (commit && !reset && (waddr == raddr1)) rdata1 = wdata;
`endif
    // Zero override is applied last so it also masks any forwarded value.
    if (ZERO_EN && (raddr1 == '0)) rdata1 = '0;
  end

  always_comb begin
    rdata2 = mem[raddr2];
`ifdef GRF_BYPASS_EN
    if (commit && !reset && (waddr == raddr2)) rdata2 = wdata;
`endif
    if (ZERO_EN && (raddr2 == '0)) rdata2 = '0;
  end

  assign eq   = (rdata1 == rdata2);
  assign lt_s = ($signed(rdata1) < $signed(rdata2));
  assign lt_u = (rdata1 < rdata2);

endmodule
